// File: rtl/otter_fetch_stage_if.sv
// Instruction-memory fetch port: one request pulse, one response strobe.
// Latency: none (wires only); the response arrives one or more cycles after the request.
// Backpressure: none on the port; the fetch side keeps at most one request in flight.
interface otter_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_rvalid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_rvalid);
endinterface

// File: rtl/otter_fetch_stage.sv
// IF stage of the OTTER pipeline: owns the PC and the IF/ID register, fetches one instruction at a time.
// Latency: memory latency + 1 cycle from request to IF/ID; one instruction every 2 cycles at best.
// Backpressure: decode stall freezes PC/IF/ID and parks a returned instruction; flush overrides everything.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                pc_next,
  input  logic                       stall,
  input  logic                       flush,
  otter_fetch_stage_if.master        imem,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  output logic [31:0]                if_id_pc,
  output logic [31:0]                if_id_ir,
  output logic                       if_id_valid,
  output logic                       fetch_misalign
);

  typedef enum logic [1:0] {S_BOOT, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t      state, state_n;
  logic        drop, drop_n;
  logic        pc_ld;
  logic        cap_mem;
  logic        cap_hold;
  logic        hold_ld;
  logic        req;
  logic [31:0] hold_ir;
  logic [31:0] hold_pc;

  assign pc_plus4       = pc + 32'd4;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  // Next-state and control decode; flush overrides stall and any response.
  always_comb begin
    state_n  = state;
    drop_n   = drop;
    pc_ld    = 1'b0;
    cap_mem  = 1'b0;
    cap_hold = 1'b0;
    hold_ld  = 1'b0;
    req      = 1'b0;
    if (flush) begin
      pc_ld = 1'b1;
      if (state == S_WAIT && !imem.imem_rvalid) begin
        // request still in flight: its response must be thrown away
        drop_n  = 1'b1;
        state_n = S_WAIT;
      end else begin
        drop_n  = 1'b0;
        state_n = S_ISSUE;
      end
    end else begin
      case (state)
        S_BOOT: state_n = S_ISSUE;
        S_ISSUE: begin
          req     = 1'b1;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = S_ISSUE;
            end else if (!stall) begin
              cap_mem = 1'b1;
              pc_ld   = 1'b1;
              state_n = S_ISSUE;
            end else begin
              hold_ld = 1'b1;
              state_n = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            cap_hold = 1'b1;
            pc_ld    = 1'b1;
            state_n  = S_ISSUE;
          end
        end
        default: state_n = S_BOOT;
      endcase
    end
  end

  // FSM state and drop-pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
    end
  end

  // PC register and sticky misalignment flag (flush clears it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_VEC;
      fetch_misalign <= 1'b0;
    end else begin
      if (pc_ld) pc <= pc_next;
      if (flush) fetch_misalign <= 1'b0;
      else if (pc_ld && (pc_next[1:0] != 2'b00)) fetch_misalign <= 1'b1;
    end
  end

  // Parking buffer for an instruction that returned while decode was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_ir <= 32'd0;
      hold_pc <= 32'd0;
    end else if (hold_ld) begin
      hold_ir <= imem.imem_rdata;
      hold_pc <= pc;
    end
  end

  // IF/ID pipeline register: squashed to a NOP on flush, loaded from memory or the parking buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_pc    <= 32'd0;
      if_id_ir    <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      if_id_ir    <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (cap_mem) begin
      if_id_pc    <= pc;
      if_id_ir    <= imem.imem_rdata;
      if_id_valid <= 1'b1;
    end else if (cap_hold) begin
      if_id_pc    <= hold_pc;
      if_id_ir    <= hold_ir;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for the OTTER fetch stage: per-cycle vector table plus hand sequences.
// Latency: inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
// Backpressure: stall/flush and memory responses come straight from the vectors.
module tb_otter_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] A0   = 32'h0010_0093;
  localparam logic [31:0] A1   = 32'h0020_0113;
  localparam logic [31:0] A2   = 32'h0030_0193;
  localparam logic [31:0] A3   = 32'h0040_0213;
  localparam logic [31:0] A4   = 32'h0050_0293;
  localparam logic [31:0] A5   = 32'h0060_0313;
  localparam logic [31:0] A6   = 32'h0070_0393;
  localparam logic [31:0] A7   = 32'h0080_0413;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        rvalid;
    logic [31:0] rdata;
    logic        man;
    logic [31:0] pn;
    logic        ereq;
    logic [31:0] epc;
    logic [31:0] eifpc;
    logic [31:0] eifir;
    logic        ev;
    logic        emis;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        stall;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_ir;
  logic        if_id_valid;
  logic        fetch_misalign;
  logic        man;
  logic [31:0] man_pc;

  int errors = 0;
  int checks = 0;

  vec_t tv[29];

  otter_fetch_stage_if imem();

  otter_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_next        (pc_next),
    .stall          (stall),
    .flush          (flush),
    .imem           (imem.master),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .if_id_pc       (if_id_pc),
    .if_id_ir       (if_id_ir),
    .if_id_valid    (if_id_valid),
    .fetch_misalign (fetch_misalign)
  );

  // PC-source mux stand-in: PC+4 unless a vector supplies a redirect target
  assign pc_next = man ? man_pc : pc_plus4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic rv, input logic [31:0] rd,
                              input logic m, input logic [31:0] p, input logic er, input logic [31:0] ep,
                              input logic [31:0] eip, input logic [31:0] eir, input logic ev, input logic em);
    vec_t v;
    v.stall = s;  v.flush = f;   v.rvalid = rv; v.rdata = rd; v.man = m; v.pn = p;
    v.ereq  = er; v.epc   = ep;  v.eifpc  = eip; v.eifir = eir; v.ev = ev; v.emis = em;
    return v;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem.imem_req}, 32'd0);
    chk({tag, "_pc"},    pc, 32'd0);
    chk({tag, "_ifpc"},  if_id_pc, 32'd0);
    chk({tag, "_ifir"},  if_id_ir, NOP);
    chk({tag, "_ifv"},   {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_mis"},   {31'd0, fetch_misalign}, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // stall flush rv rdata man pn | req pc ifpc ifir v mis
    tv[0]  = mk(0,0,0,32'd0,0,32'd0,     0,32'h000,32'h000,NOP,0,0); // BOOT
    tv[1]  = mk(0,0,0,32'd0,0,32'd0,     1,32'h000,32'h000,NOP,0,0); // first request
    tv[2]  = mk(0,0,1,A0,   0,32'd0,     0,32'h000,32'h000,NOP,0,0);
    tv[3]  = mk(0,0,0,32'd0,0,32'd0,     1,32'h004,32'h000,A0, 1,0);
    tv[4]  = mk(0,0,1,A1,   0,32'd0,     0,32'h004,32'h000,A0, 1,0);
    tv[5]  = mk(0,0,0,32'd0,0,32'd0,     1,32'h008,32'h004,A1, 1,0);
    tv[6]  = mk(0,0,1,A2,   0,32'd0,     0,32'h008,32'h004,A1, 1,0);
    tv[7]  = mk(0,0,0,32'd0,0,32'd0,     1,32'h00C,32'h008,A2, 1,0);
    tv[8]  = mk(1,0,1,A3,   0,32'd0,     0,32'h00C,32'h008,A2, 1,0); // response under stall
    tv[9]  = mk(1,0,0,32'd0,0,32'd0,     0,32'h00C,32'h008,A2, 1,0); // HOLD, no request
    tv[10] = mk(1,0,0,32'd0,0,32'd0,     0,32'h00C,32'h008,A2, 1,0);
    tv[11] = mk(0,0,0,32'd0,0,32'd0,     0,32'h00C,32'h008,A2, 1,0); // release
    tv[12] = mk(0,0,0,32'd0,0,32'd0,     1,32'h010,32'h00C,A3, 1,0);
    tv[13] = mk(0,1,0,32'd0,1,32'h100,   0,32'h010,32'h00C,A3, 1,0); // flush while waiting
    tv[14] = mk(0,0,0,32'd0,0,32'd0,     0,32'h100,32'h00C,NOP,0,0);
    tv[15] = mk(0,0,1,JUNK, 0,32'd0,     0,32'h100,32'h00C,NOP,0,0); // stale response dropped
    tv[16] = mk(0,0,0,32'd0,0,32'd0,     1,32'h100,32'h00C,NOP,0,0);
    tv[17] = mk(1,0,1,A4,   0,32'd0,     0,32'h100,32'h00C,NOP,0,0); // into HOLD
    tv[18] = mk(1,1,0,32'd0,1,32'h180,   0,32'h100,32'h00C,NOP,0,0); // flush + stall in HOLD
    tv[19] = mk(0,0,0,32'd0,0,32'd0,     1,32'h180,32'h00C,NOP,0,0);
    tv[20] = mk(0,0,1,A5,   1,32'h102,   0,32'h180,32'h00C,NOP,0,0); // misaligned target
    tv[21] = mk(0,0,0,32'd0,0,32'd0,     1,32'h102,32'h180,A5, 1,1);
    tv[22] = mk(0,0,1,A6,   0,32'd0,     0,32'h102,32'h180,A5, 1,1);
    tv[23] = mk(0,0,0,32'd0,0,32'd0,     1,32'h106,32'h102,A6, 1,1);
    tv[24] = mk(0,1,0,32'd0,1,32'h200,   0,32'h106,32'h102,A6, 1,1); // flush clears misalign
    tv[25] = mk(0,0,1,JUNK, 0,32'd0,     0,32'h200,32'h102,NOP,0,0);
    tv[26] = mk(0,0,1,JUNK, 0,32'd0,     1,32'h200,32'h102,NOP,0,0); // rvalid outside WAIT
    tv[27] = mk(0,0,1,A7,   0,32'd0,     0,32'h200,32'h102,NOP,0,0);
    tv[28] = mk(0,0,0,32'd0,0,32'd0,     1,32'h204,32'h200,A7, 1,0);

    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    man = 1'b0;
    man_pc = 32'd0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      stall = tv[i].stall;
      flush = tv[i].flush;
      imem.imem_rvalid = tv[i].rvalid;
      imem.imem_rdata = tv[i].rdata;
      man = tv[i].man;
      man_pc = tv[i].pn;
      #4;
      chk($sformatf("v%0d_req", i),  {31'd0, imem.imem_req}, {31'd0, tv[i].ereq});
      chk($sformatf("v%0d_pc", i),   pc, tv[i].epc);
      chk($sformatf("v%0d_pc4", i),  pc_plus4, tv[i].epc + 32'd4);
      chk($sformatf("v%0d_ifpc", i), if_id_pc, tv[i].eifpc);
      chk($sformatf("v%0d_ifir", i), if_id_ir, tv[i].eifir);
      chk($sformatf("v%0d_ifv", i),  {31'd0, if_id_valid}, {31'd0, tv[i].ev});
      chk($sformatf("v%0d_mis", i),  {31'd0, fetch_misalign}, {31'd0, tv[i].emis});
      if (tv[i].ereq) chk($sformatf("v%0d_addr", i), imem.imem_addr, tv[i].epc);
      next_cycle();
    end

    // Wrap-around: redirect to the top word, then let PC+4 roll over to zero.
    stall = 1'b0;
    imem.imem_rvalid = 1'b0;
    flush = 1'b1;
    man = 1'b1;
    man_pc = 32'hFFFF_FFFC;
    next_cycle();
    flush = 1'b0;
    man = 1'b0;
    #4;
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0000_0000);
    next_cycle();
    imem.imem_rvalid = 1'b1;      // response to the flushed request
    imem.imem_rdata = JUNK;
    next_cycle();
    imem.imem_rvalid = 1'b0;
    #4;
    chk("wrap_req", {31'd0, imem.imem_req}, 32'd1);
    chk("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = A0;
    next_cycle();
    imem.imem_rvalid = 1'b0;
    #4;
    chk("wrap_pc_after", pc, 32'h0000_0000);
    chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_ifir", if_id_ir, A0);
    chk("wrap_req2", {31'd0, imem.imem_req}, 32'd1);
    next_cycle();

    // Reset in the middle of an outstanding request; the response is ignored.
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    imem.imem_rvalid = 1'b1;
    imem.imem_rdata = JUNK;
    next_cycle();
    imem.imem_rvalid = 1'b0;
    rst_n = 1'b1;
    #4;
    chk("boot_req", {31'd0, imem.imem_req}, 32'd0);
    chk("boot_ifir", if_id_ir, NOP);
    next_cycle();
    #4;
    chk("reboot_req", {31'd0, imem.imem_req}, 32'd1);
    chk("reboot_addr", imem.imem_addr, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
